// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes engine: substitutes LANES bytes of a 128-bit state
// per clock in forward or inverse mode, with valid/ready on both sides.
module sub_bytes_engine #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         asy_reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned ITER = 16 / LANES;
  localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [127:0]    work, work_nxt;
  logic            inv_q;
  logic [CW-1:0]   cnt;
  logic            last;
  logic            accept;
  logic [7:0]      lane_in  [LANES];
  logic [7:0]      lane_out [LANES];

  // GF(2^8) helpers, reduction polynomial x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int unsigned i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  assign last      = (cnt == CW'(ITER - 1));
  assign in_ready  = asy_reset & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign out_state = work;
  assign busy      = (state_q == BUSY);

  // Gather the byte group addressed by cnt into the S-box lanes
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) lane_in[l] = '0;
    for (int unsigned b = 0; b < 16; b++) begin
      if (CW'(b / LANES) == cnt) lane_in[b % LANES] = work[8*(15-b) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] fwd_o;
    logic [7:0] inv_o;
    assign fwd_o       = fwd_sbox(lane_in[g]);
    assign inv_o       = inv_sbox(lane_in[g]);
    assign lane_out[g] = inv_q ? inv_o : fwd_o;
  end

  // Scatter substituted lanes back into their byte slots, others hold
  always_comb begin
    work_nxt = work;
    for (int unsigned b = 0; b < 16; b++) begin
      if (CW'(b / LANES) == cnt) work_nxt[8*(15-b) +: 8] = lane_out[b % LANES];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge asy_reset) begin
    if (!asy_reset) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Datapath: latch block on acceptance, substitute one group per BUSY cycle
  always_ff @(posedge clk or negedge asy_reset) begin
    if (!asy_reset) begin
      work  <= '0;
      inv_q <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      work  <= in_state;
      inv_q <= in_inv;
      cnt   <= '0;
    end else if (state_q == BUSY) begin
      work  <= work_nxt;
      cnt   <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench: five engines (LANES 1,2,4,8,16) share one input bus
// and are checked against a table-based S-box model built at start-up.
module tb_sub_bytes_engine;

  logic         clk = 1'b0;
  logic         asy_reset;
  logic         in_valid;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_ready;
  logic [4:0]   in_ready;
  logic [4:0]   out_valid;
  logic [4:0]   busy;
  logic [127:0] out_state [5];

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_f [256];
  logic [7:0] sbox_i [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .asy_reset (asy_reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_state (out_state[g]),
      .busy      (busy[g])
    );
  end

  // Reference model: textbook S-box tables
  function automatic int gmul(int a, int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if ((b >> i) & 1) p = p ^ a;
      a = a << 1;
      if (a & 'h100) a = a ^ 'h11b;
    end
    return p;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      int inv;
      logic [7:0] v;
      logic [7:0] r;
      logic [7:0] c;
      inv = 0;
      for (int y = 1; y < 256; y++) if (gmul(x, y) == 1) inv = y;
      v = inv[7:0];
      c = 8'h63;
      for (int i = 0; i < 8; i++)
        r[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      sbox_f[x] = r;
    end
    for (int x = 0; x < 256; x++) sbox_i[sbox_f[x]] = x[7:0];
  endtask

  function automatic logic [127:0] model(logic [127:0] s, logic mode);
    logic [127:0] r;
    for (int k = 0; k < 16; k++)
      r[8*(15-k) +: 8] = mode ? sbox_i[s[8*(15-k) +: 8]] : sbox_f[s[8*(15-k) +: 8]];
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] observed, logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Presents a block (caller sets out_ready), waits up to 20 cycles for each
  // engine's result, then checks latency, value and DONE-state handshake.
  task automatic run_block(string tag, logic [127:0] s, logic mode, bit toggle, logic [127:0] exp);
    int lat [5];
    logic [127:0] first [5];
    in_valid = 1'b1;
    in_state = s;
    in_inv   = mode;
    for (int g = 0; g < 5; g++) begin lat[g] = -1; first[g] = '0; end
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      out_ready = 1'b0;
      if (toggle) begin
        in_valid = 1'($urandom);
        in_inv   = 1'($urandom);
        in_state = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      if (k == 0) chk({tag, "_busy"}, 128'(busy), 128'h1f);
      for (int g = 0; g < 5; g++)
        if (lat[g] < 0 && out_valid[g]) begin lat[g] = k; first[g] = out_state[g]; end
    end
    in_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("%s_lat_l%0d", tag, 1 << g), 128'(lat[g]), 128'(16 >> g));
      chk($sformatf("%s_first_l%0d", tag, 1 << g), first[g], exp);
      chk($sformatf("%s_held_l%0d", tag, 1 << g), out_state[g], exp);
    end
    chk({tag, "_ovalid"}, 128'(out_valid), 128'h1f);
    chk({tag, "_iready"}, 128'(in_ready), 128'h0);
  endtask

  task automatic drain(string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drain_ov"}, 128'(out_valid), 128'h0);
    chk({tag, "_drain_ir"}, 128'(in_ready), 128'h1f);
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] exp;
    logic         m;

    asy_reset = 1'b0;
    in_valid  = 1'b0;
    in_state  = '0;
    in_inv    = 1'b0;
    out_ready = 1'b0;
    build_tables();
    repeat (2) @(negedge clk);

    chk("rst_ir", 128'(in_ready), 128'h0);
    chk("rst_ov", 128'(out_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    for (int g = 0; g < 5; g++) chk($sformatf("rst_os_l%0d", 1 << g), out_state[g], '0);
    asy_reset = 1'b1;
    #1;
    chk("rel_ir", 128'(in_ready), 128'h1f);
    @(negedge clk);

    run_block("fips_fwd", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 1'b0,
              128'hd42711aee0bf98f1b8b45de51e415230);
    drain("fips_fwd");
    run_block("fips_inv", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 1'b0,
              128'h193de3bea0f4e22b9ac68d2ae9f84808);
    drain("fips_inv");
    run_block("zero_fwd", '0, 1'b0, 1'b0, {16{8'h63}});
    drain("zero_fwd");
    run_block("x53_fwd", {16{8'h53}}, 1'b0, 1'b0, {16{8'hed}});
    drain("x53_fwd");

    // Inputs toggled while busy must not disturb the latched block or mode
    run_block("fips_tgl", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0, 1'b1,
              128'hd42711aee0bf98f1b8b45de51e415230);
    drain("fips_tgl");

    for (int i = 0; i < 6; i++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      run_block($sformatf("rnd%0d", i), s, m, 1'(i), model(s, m));
      drain($sformatf("rnd%0d", i));
    end

    // Backpressure, then back-to-back acceptance on the consuming edge
    s   = {$urandom, $urandom, $urandom, $urandom};
    exp = model(s, 1'b0);
    run_block("bp", s, 1'b0, 1'b0, exp);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c), out_state[0], exp);
      chk($sformatf("bp_ir%0d", c), 128'(in_ready), 128'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_ir", 128'(in_ready), 128'h1f);
    run_block("b2b", {16{8'h63}}, 1'b1, 1'b0, '0);
    drain("b2b");

    // Reset two cycles into BUSY
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 asy_reset = 1'b0;
    #1;
    chk("mrst_ov", 128'(out_valid), 128'h0);
    chk("mrst_ir", 128'(in_ready), 128'h0);
    for (int g = 0; g < 5; g++) chk($sformatf("mrst_os_l%0d", 1 << g), out_state[g], '0);
    @(negedge clk);
    asy_reset = 1'b1;
    #1;
    chk("mrel_ir", 128'(in_ready), 128'h1f);
    chk("mrel_busy", 128'(busy), 128'h0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("mrel_nostale%0d", c), 128'(out_valid), 128'h0);
    end

    s = {$urandom, $urandom, $urandom, $urandom};
    run_block("post_rst", s, 1'b1, 1'b0, model(s, 1'b1));
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Parametrised, iterative SubBytes unit for the AES-128/256 datapath. It replaces the fixed 16-S-box, single-register substitution stage. It processes `LANES` bytes per clock, supports forward (encrypt) and inverse (decrypt) substitution selected per block, and uses a valid/ready handshake on both sides. Area can therefore be traded against throughput while sitting between AddRoundKey and ShiftRows in either round pipeline.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value must fail elaboration.
- `ITER`, derived as 16/`LANES`: processing cycles per block. Not overridable.
- `clk`  input  1  clock; all state updates on the rising edge.
- `asy_reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_state` and `in_inv` are presented.
- `in_ready`  output  1  engine can accept a block this cycle.
- `in_state`  input  128  state array, column-major; byte 0 = [127:120], byte 15 = [7:0].
- `in_inv`  input  1  0 = forward S-box, 1 = inverse S-box.
- `out_valid`  output  1  `out_state` holds a finished block.
- `out_ready`  input  1  downstream accepts `out_state`.
- `out_state`  output  128  substituted state, same byte layout as `in_state`.
- `busy`  output  1  high while in the BUSY state.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- Working register `work[127:0]`, mode register `inv_q`, byte-group counter `cnt` of width max(1, clog2(`ITER`)).
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid` & `in_ready`: `work` <= `in_state`, `inv_q` <= `in_inv`, `cnt` <= 0, go to BUSY.
- **BUSY**
  - Each cycle, bytes `cnt*LANES` to `cnt*LANES+LANES-1` of `work` are replaced in place by the S-box output. Forward S-box when `inv_q`=0, inverse S-box when `inv_q`=1.
  - All other bytes of `work` hold their value.
  - `cnt` increments. When `cnt` = `ITER`-1, that edge writes the last group and moves to DONE.
  - `in_valid` is ignored in BUSY.
- **DONE**
  - `out_valid` = 1 and `out_state` = `work`. Both are held stable while `out_ready` = 0.
  - On `out_ready` = 1 the block is consumed. If `in_valid` is also 1 the same edge accepts a new block and goes to BUSY (back-to-back). Otherwise go to IDLE.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`), gated low while `asy_reset` = 0.
- S-box logic: exactly `LANES` forward and `LANES` inverse S-box instances, muxed by `inv_q`. The mode does not change inside a block.
- `LANES`=16: BUSY lasts one cycle, so one block completes every 2 cycles when backpressure-free with back-to-back acceptance.

## Timing
- Reset (asynchronous assert, values take effect immediately):
  - state=IDLE, `work`=128'h0, `inv_q`=0, `cnt`=0.
  - `out_valid`=0, `out_state`=128'h0, `busy`=0, `in_ready`=0 while reset is low.
- Latency: acceptance at edge E0; `out_valid` rises after edge E0+`ITER`, i.e. `ITER` cycles later.
- Throughput: one block per `ITER`+1 cycles with `out_ready` tied high.
- Reset mid-BUSY or mid-DONE aborts the block. No output is produced for it, and the first cycle after reset release shows IDLE with `in_ready`=1.
- `out_state` is registered and contains no combinational path from `in_state`.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.

## Test plan
- **Forward, FIPS-197 round-1 vector.** `LANES`=4, `in_state`=193de3bea0f4e22b9ac68d2ae9f84808, `in_inv`=0 → after 4 cycles `out_valid`=1, `out_state`=d42711aee0bf98f1b8b45de51e415230.
- **Inverse round-trip.** Feed d42711aee0bf98f1b8b45de51e415230 with `in_inv`=1 → `out_state`=193de3bea0f4e22b9ac68d2ae9f84808.
- **Parameter sweep.** Run the all-0x00 block with `in_inv`=0 at `LANES`=1, 2, 8, 16 → `out_state`=128'h6363…63 at latency 16, 8, 2, 1. Run the all-0x53 block with `in_inv`=0 → all 0xED.
- **Backpressure plus back-to-back.**
  - Hold `out_ready`=0 for 5 cycles in DONE: `out_state` stable, `in_ready`=0.
  - Raise `out_ready` with `in_valid`=1 and the next block (all-0x63, `in_inv`=1): the new block is accepted on the same edge, and the next output is all-0x00.
- **Reset mid-operation.** Assert `asy_reset`=0 two cycles into BUSY → `out_valid`=0, `out_state`=0 immediately. After release, `in_ready`=1 and no stale output ever appears.
- **Ignored input in BUSY.** Toggle `in_valid` and `in_inv` during BUSY → result unchanged and still equal to the mode latched at acceptance.
